// File: rtl/hht_pkg.sv
// Shared types and default sizes for the HHT column-engine fetch sequencer.
package hht_pkg;

    // Defaults for the sequencer's parameters
    localparam int unsigned HHT_DATA_W = 32;
    localparam int unsigned HHT_V_SIZE = 9;
    localparam int unsigned HHT_SEL_W  = 4;

    typedef enum logic [1:0] {
        IDLE,
        LOAD_V,
        STREAM,
        DONE
    } hht_sched_state_t;

endpackage

// File: rtl/hht_mod_cnt.sv
// Modulo-MOD counter with synchronous clear and increment; wraps MOD-1 -> 0.
module hht_mod_cnt #(
    parameter int unsigned MOD = 9,
    parameter int unsigned W   = 4
) (
    input  logic         Clk,
    input  logic         Rst,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic at_max;

    assign at_max = (count == W'(MOD - 1));

    // Count state: clear has priority over increment
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            count <= '0;
        end else if (clr) begin
            count <= '0;
        end else if (inc) begin
            count <= at_max ? '0 : count + W'(1);
        end
    end

endmodule

// File: rtl/hht_fetch_sched.sv
// Fetch sequencer for the HHT column engine: loads the v-value bank, then streams column
// words through one shared combinational read port under a valid/ready handshake.
module hht_fetch_sched
    import hht_pkg::*;
#(
    parameter int unsigned DATA_W = HHT_DATA_W,
    parameter int unsigned V_SIZE = HHT_V_SIZE,
    parameter int unsigned SEL_W  = HHT_SEL_W
) (
    input  logic                     Clk,
    input  logic                     Rst,
    input  logic                     start,
    input  logic [DATA_W-1:0]        v_base,
    input  logic [DATA_W-1:0]        col_base,
    input  logic [DATA_W-1:0]        csize,
    output logic [DATA_W-1:0]        mem_addr,
    output logic                     mem_rd,
    input  logic [DATA_W-1:0]        mem_rdata,
    output logic [V_SIZE*DATA_W-1:0] v_vals,
    output logic [DATA_W-1:0]        col_data,
    output logic                     col_valid,
    input  logic                     col_ready,
    output logic [SEL_W-1:0]         v_sel,
    output logic                     busy,
    output logic                     done
);

    hht_sched_state_t state;

    logic [DATA_W-1:0]        v_base_q;
    logic [DATA_W-1:0]        col_base_q;
    logic [DATA_W-1:0]        csize_q;
    logic [DATA_W-1:0]        ci;
    logic [V_SIZE*DATA_W-1:0] v_bank;
    logic [SEL_W-1:0]         vi;
    logic [SEL_W-1:0]         sel;
    logic                     accept;
    logic                     handshake;
    logic                     vi_last;

    assign accept    = (state == IDLE) && start;
    assign handshake = (state == STREAM) && col_ready;
    assign vi_last   = (vi == SEL_W'(V_SIZE - 1));
    assign v_vals    = v_bank;

    // Index of the v-value being loaded
    hht_mod_cnt #(
        .MOD (V_SIZE),
        .W   (SEL_W)
    ) u_vi_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .clr   (accept),
        .inc   (state == LOAD_V),
        .count (vi)
    );

    // v-value selector for the current column word, advances on each accepted beat
    hht_mod_cnt #(
        .MOD (V_SIZE),
        .W   (SEL_W)
    ) u_sel_cnt (
        .Clk   (Clk),
        .Rst   (Rst),
        .clr   (accept),
        .inc   (handshake),
        .count (sel)
    );

    // Job FSM with captured job parameters, stream index and the v-value bank
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state      <= IDLE;
            v_base_q   <= '0;
            col_base_q <= '0;
            csize_q    <= '0;
            ci         <= '0;
            v_bank     <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (start) begin
                        v_base_q   <= v_base;
                        col_base_q <= col_base;
                        csize_q    <= csize;
                        ci         <= '0;
                        state      <= LOAD_V;
                    end
                end
                LOAD_V: begin
                    for (int k = 0; k < V_SIZE; k++) begin
                        if (vi == SEL_W'(k)) begin
                            v_bank[k*DATA_W +: DATA_W] <= mem_rdata;
                        end
                    end
                    if (vi_last) begin
                        state <= (csize_q != '0) ? STREAM : DONE;
                    end
                end
                STREAM: begin
                    if (col_ready) begin
                        ci <= ci + DATA_W'(1);
                        if (ci == csize_q - DATA_W'(1)) begin
                            state <= DONE;
                        end
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    // Memory port and datapath outputs decoded from the current state
    always_comb begin
        mem_rd    = 1'b0;
        mem_addr  = '0;
        col_valid = 1'b0;
        col_data  = '0;
        v_sel     = '0;
        busy      = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
            end
            LOAD_V: begin
                mem_rd   = 1'b1;
                mem_addr = v_base_q + DATA_W'(vi);
                busy     = 1'b1;
            end
            STREAM: begin
                mem_rd    = 1'b1;
                mem_addr  = col_base_q + ci;
                col_valid = 1'b1;
                col_data  = mem_rdata;
                v_sel     = sel;
                busy      = 1'b1;
            end
            DONE: begin
                done = 1'b1;
            end
            default: begin
            end
        endcase
    end

endmodule
